// File: rtl/ir_pkg.sv
// Shared types and constants for the instruction assembly register.
package ir_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } ir_state_t;

    localparam logic SEQ    = 1'b0;
    localparam logic DIRECT = 1'b1;

    localparam int DEF_BUS_W   = 8;
    localparam int DEF_INSTR_W = 16;

endpackage

// File: rtl/ir_assembly_buffer.sv
// LANES x BUS_W assembly register with per-lane write enable and synchronous clear.
module ir_assembly_buffer #(
    parameter int BUS_W = 8,
    parameter int LANES = 2
) (
    input  logic                   Clock,
    input  logic                   ResetN,
    input  logic                   clear,
    input  logic [LANES-1:0]       we,
    input  logic [BUS_W-1:0]       wdata,
    output logic [LANES*BUS_W-1:0] q
);

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (we[i]) q[i*BUS_W +: BUS_W] <= wdata;
            end
        end
    end

endmodule

// File: rtl/instruction_assembly_register.sv
// Assembles BUS_W fetch beats into an INSTR_W instruction and hands it to a consumer.
//   state   | meaning
//   COLLECT | accepting beats; completed words go straight to IROut when it is free
//   HOLD    | completed word parked in the buffer until the consumer takes IROut
module instruction_assembly_register
    import ir_pkg::*;
#(
    parameter int  BUS_W   = DEF_BUS_W,
    parameter int  INSTR_W = DEF_INSTR_W,
    localparam int LANES   = INSTR_W / BUS_W,
    localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic               Clock,
    input  logic               ResetN,
    input  logic               Write,
    output logic               WReady,
    input  logic               Mode,
    input  logic [LW-1:0]      Lane,
    input  logic               Last,
    input  logic [BUS_W-1:0]   I,
    input  logic               Flush,
    input  logic               Take,
    output logic [INSTR_W-1:0] IROut,
    output logic               IRValid,
    output logic [LW-1:0]      BeatCnt,
    output logic               LaneErr
);

    ir_state_t            state, state_d;
    logic [INSTR_W-1:0]   buf_q, merged, ir_d;
    logic [LANES-1:0]     we;
    logic [LW-1:0]        wr_lane;
    logic                 accept, seq, direct_ok, lane_we, complete, valid_d;

    assign WReady    = (state == COLLECT);
    assign accept    = Write && WReady && !Flush;
    assign seq       = (Mode == SEQ);
    assign direct_ok = (int'(Lane) < LANES) && (BeatCnt == '0);
    assign wr_lane   = seq ? BeatCnt : Lane;
    assign lane_we   = accept && (seq || direct_ok);
    assign complete  = lane_we && (seq ? (BeatCnt == LW'(LANES - 1)) : Last);

    // The completing beat lands in the buffer on the same edge, so the
    // committed word is built from the buffer with that beat merged in.
    always_comb begin
        merged = buf_q;
        we     = '0;
        for (int i = 0; i < LANES; i++) begin
            if (lane_we && (wr_lane == LW'(i))) begin
                we[i]                   = 1'b1;
                merged[i*BUS_W +: BUS_W] = I;
            end
        end
    end

    ir_assembly_buffer #(
        .BUS_W (BUS_W),
        .LANES (LANES)
    ) u_buf (
        .Clock  (Clock),
        .ResetN (ResetN),
        .clear  (Flush),
        .we     (we),
        .wdata  (I),
        .q      (buf_q)
    );

    always_comb begin
        state_d = state;
        ir_d    = IROut;
        valid_d = IRValid;
        if (Flush) begin
            state_d = COLLECT;
            ir_d    = '0;
            valid_d = 1'b0;
        end else if (state == HOLD) begin
            if (Take) begin
                ir_d    = buf_q;
                valid_d = 1'b1;
                state_d = COLLECT;
            end
        end else if (complete) begin
            if (!IRValid || Take) begin
                ir_d    = merged;
                valid_d = 1'b1;
            end else begin
                state_d = HOLD;
            end
        end else if (Take && IRValid) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state   <= COLLECT;
            IROut   <= '0;
            IRValid <= 1'b0;
            BeatCnt <= '0;
            LaneErr <= 1'b0;
        end else begin
            state   <= state_d;
            IROut   <= ir_d;
            IRValid <= valid_d;
            if (Flush) begin
                BeatCnt <= '0;
                LaneErr <= 1'b0;
            end else if (accept) begin
                if (seq) begin
                    BeatCnt <= complete ? '0 : BeatCnt + 1'b1;
                end else if (!direct_ok) begin
                    LaneErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_assembly_register.sv
// Directed bench for instruction_assembly_register with 16-, 24- and 32-bit instances.
module tb_instruction_assembly_register;
    import ir_pkg::*;

    logic Clock = 1'b0;
    logic ResetN;
    logic w16, w24, w32;
    logic Mode, Last, Flush, Take;
    logic [1:0] lane_sel;
    logic [7:0] I;

    logic        wr16, wr24, wr32;
    logic [15:0] ir16;
    logic [23:0] ir24;
    logic [31:0] ir32;
    logic        v16, v24, v32;
    logic [0:0]  bc16;
    logic [1:0]  bc24, bc32;
    logic        le16, le24, le32;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clock = ~Clock;

    instruction_assembly_register #(.BUS_W(8), .INSTR_W(16)) dut16 (
        .Clock(Clock), .ResetN(ResetN), .Write(w16), .WReady(wr16), .Mode(Mode),
        .Lane(lane_sel[0:0]), .Last(Last), .I(I), .Flush(Flush), .Take(Take),
        .IROut(ir16), .IRValid(v16), .BeatCnt(bc16), .LaneErr(le16));

    instruction_assembly_register #(.BUS_W(8), .INSTR_W(24)) dut24 (
        .Clock(Clock), .ResetN(ResetN), .Write(w24), .WReady(wr24), .Mode(Mode),
        .Lane(lane_sel), .Last(Last), .I(I), .Flush(Flush), .Take(Take),
        .IROut(ir24), .IRValid(v24), .BeatCnt(bc24), .LaneErr(le24));

    instruction_assembly_register #(.BUS_W(8), .INSTR_W(32)) dut32 (
        .Clock(Clock), .ResetN(ResetN), .Write(w32), .WReady(wr32), .Mode(Mode),
        .Lane(lane_sel), .Last(Last), .I(I), .Flush(Flush), .Take(Take),
        .IROut(ir32), .IRValid(v32), .BeatCnt(bc32), .LaneErr(le32));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        ResetN = 1'b0; w16 = 0; w24 = 0; w32 = 0;
        Mode = SEQ; Last = 0; Flush = 0; Take = 0; lane_sel = 0; I = 0;
        #12;
        chk("rst_irout",   32'(ir16), 32'h0);
        chk("rst_irvalid", 32'(v16),  32'h0);
        chk("rst_wready",  32'(wr16), 32'h1);
        chk("rst_beatcnt", 32'(bc16), 32'h0);
        chk("rst_laneerr", 32'(le16), 32'h0);
        @(negedge Clock);
        ResetN = 1'b1;
        cyc();

        // sequential fill
        w16 = 1; I = 8'h34; cyc();
        chk("seq_beat1_cnt",   32'(bc16), 32'h1);
        chk("seq_beat1_valid", 32'(v16),  32'h0);
        I = 8'h12; cyc();
        chk("seq_word",  32'(ir16), 32'h1234);
        chk("seq_valid", 32'(v16),  32'h1);
        chk("seq_cnt",   32'(bc16), 32'h0);

        // completion while IROut unconsumed -> HOLD
        I = 8'hCD; cyc();
        I = 8'hAB; cyc();
        chk("hold_wready", 32'(wr16), 32'h0);
        chk("hold_irout",  32'(ir16), 32'h1234);
        I = 8'hEE; cyc();
        chk("hold_nowrite_cnt", 32'(bc16), 32'h0);
        w16 = 0; Take = 1; cyc();
        Take = 0;
        chk("hold_take_irout",  32'(ir16), 32'hABCD);
        chk("hold_take_wready", 32'(wr16), 32'h1);
        chk("hold_take_valid",  32'(v16),  32'h1);

        // completion together with Take
        w16 = 1; I = 8'h11; cyc();
        I = 8'h22; Take = 1; cyc();
        chk("ctake_irout",  32'(ir16), 32'h2211);
        chk("ctake_valid",  32'(v16),  32'h1);
        chk("ctake_wready", 32'(wr16), 32'h1);
        w16 = 0; cyc();
        chk("take_clear_valid", 32'(v16),  32'h0);
        chk("take_persist",     32'(ir16), 32'h2211);
        cyc();
        chk("take_idle_valid", 32'(v16), 32'h0);
        Take = 0;

        // direct lane writes
        w16 = 1; Mode = DIRECT; lane_sel = 2'd1; Last = 0; I = 8'h56; cyc();
        chk("dir_partial_valid", 32'(v16), 32'h0);
        lane_sel = 2'd0; Last = 1; I = 8'h78; cyc();
        chk("dir_word", 32'(ir16), 32'h5678);
        lane_sel = 2'd1; Last = 1; I = 8'h9A; Take = 1; cyc();
        Take = 0;
        chk("dir_retain", 32'(ir16), 32'h9A78);
        Mode = SEQ; Last = 0; I = 8'h01; cyc();
        Mode = DIRECT; lane_sel = 2'd0; Last = 1; I = 8'hFF; cyc();
        chk("dir_midseq_err",  32'(le16), 32'h1);
        chk("dir_midseq_cnt",  32'(bc16), 32'h1);
        chk("dir_midseq_word", 32'(ir16), 32'h9A78);
        Flush = 1; cyc();
        Flush = 0; w16 = 0;
        chk("flush16_err",   32'(le16), 32'h0);
        chk("flush16_valid", 32'(v16),  32'h0);
        chk("flush16_irout", 32'(ir16), 32'h0);
        chk("flush16_cnt",   32'(bc16), 32'h0);

        // out-of-range lane on a 3-lane instance
        w24 = 1; Mode = DIRECT; lane_sel = 2'd3; Last = 1; I = 8'hAA; cyc();
        chk("lane3_err",   32'(le24), 32'h1);
        chk("lane3_valid", 32'(v24),  32'h0);
        lane_sel = 2'd2; I = 8'hBB; cyc();
        w24 = 0;
        chk("lane2_word",   32'(ir24), 32'hBB0000);
        chk("lane2_sticky", 32'(le24), 32'h1);

        // 32-bit: three beats then Flush with Write
        w32 = 1; Mode = SEQ; Last = 0;
        I = 8'h11; cyc();
        I = 8'h22; cyc();
        I = 8'h33; cyc();
        chk("w32_cnt3", 32'(bc32), 32'h3);
        I = 8'h44; Flush = 1; cyc();
        Flush = 0;
        chk("w32_flush_cnt",   32'(bc32), 32'h0);
        chk("w32_flush_valid", 32'(v32),  32'h0);
        Mode = DIRECT; lane_sel = 2'd0; Last = 1; I = 8'h55; cyc();
        w32 = 0;
        chk("w32_buf_zero", ir32, 32'h00000055);

        // asynchronous reset mid-assembly
        w16 = 1; Mode = SEQ; Last = 0; I = 8'h77; cyc();
        w16 = 0;
        chk("pre_rst_cnt", 32'(bc16), 32'h1);
        #2 ResetN = 1'b0;
        #1;
        chk("arst_cnt",    32'(bc16), 32'h0);
        chk("arst_irout",  ir32,      32'h0);
        chk("arst_valid",  32'(v32),  32'h0);
        chk("arst_err24",  32'(le24), 32'h0);
        @(negedge Clock);
        ResetN = 1'b1;
        cyc();
        w16 = 1; I = 8'h10; cyc();
        I = 8'h20; cyc();
        w16 = 0;
        chk("resume_word", 32'(ir16), 32'h2010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
